// File: rtl/wheel_sched_pkg.sv
// Shared types and helpers for the wheel update scheduler.
//   state_e      - sequencer states
//   acc_width()  - accumulator width that holds SUBSTEPS full-scale forces
//   force_pair_t - (x,y) force pair at the default updater width
package wheel_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_NEXT    = 3'd3,
    ST_PUBLISH = 3'd4
  } state_e;

  // SUBSTEPS is a power of two, so log2 extra bits cover SUBSTEPS x full scale.
  function automatic int acc_width(input int force_size, input int substeps);
    return force_size + $clog2(substeps);
  endfunction

  localparam int FORCE_SIZE_DEF = 8;

  typedef struct packed {
    logic signed [FORCE_SIZE_DEF-1:0] y;
    logic signed [FORCE_SIZE_DEF-1:0] x;
  } force_pair_t;

endpackage

// File: rtl/update_watchdog.sv
// Cycle watchdog for one updater request.
//   clk, rst - clock, async active-high reset
//   clear    - restart the count (takes priority over run)
//   run      - count this cycle
//   expire   - high while running on the LIMIT-th counted cycle
module update_watchdog #(
  parameter int  LIMIT = 4096,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at LAST so an ignored expire cannot wrap into a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt_q <= '0;
    else if (clear)                  cnt_q <= '0;
    else if (run && cnt_q != LAST)   cnt_q <= cnt_q + 1'b1;
  end

  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/wheel_update_scheduler.sv
// Frame sequencer for the shared wheel physics updater. Each frame tick runs
// SUBSTEPS passes over all wheels through one updater (begin/done handshake),
// accumulates per-wheel (x,y) force and publishes the totals.
// Optional feature macro: UPDATE_WATCHDOG_EN (per-request timeout -> error_out).
// Ports:
//   clk_in, rst_in   - clock, async active-high reset
//   frame_in         - frame tick; pause_in blocks it while idle
//   begin_out        - one-cycle updater start
//   wheel_sel_out    - wheel routed to the updater
//   done_in,force_in - updater completion and its (x,y) force
//   forces_out       - per-wheel frame totals [wheel][axis], axis 0 = x
//   frame_done_out   - pulse, forces_out just updated
//   busy_out         - not idle
//   overrun_out      - sticky, tick arrived while busy
//   error_out        - sticky, watchdog abort (0 without the macro)
module wheel_update_scheduler
  import wheel_sched_pkg::*;
#(
  parameter int  NUM_WHEELS     = 2,
  parameter int  SUBSTEPS       = 4,
  parameter int  FORCE_SIZE     = 8,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int ACC_W          = acc_width(FORCE_SIZE, SUBSTEPS),
  localparam int SEL_W          = $clog2(NUM_WHEELS)
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         frame_in,
  input  logic                                         pause_in,
  output logic                                         begin_out,
  output logic [SEL_W-1:0]                             wheel_sel_out,
  input  logic                                         done_in,
  input  logic signed [1:0][FORCE_SIZE-1:0]            force_in,
  output logic signed [NUM_WHEELS-1:0][1:0][ACC_W-1:0] forces_out,
  output logic                                         frame_done_out,
  output logic                                         busy_out,
  output logic                                         overrun_out,
  output logic                                         error_out
);

  localparam int SUB_W = $clog2(SUBSTEPS);
  localparam int EXT_W = ACC_W - FORCE_SIZE;
  localparam logic [SEL_W-1:0] LAST_WHEEL = SEL_W'(NUM_WHEELS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB   = SUB_W'(SUBSTEPS - 1);

  if (NUM_WHEELS < 2 || SUBSTEPS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("wheel_update_scheduler: NUM_WHEELS, SUBSTEPS, TIMEOUT_CYCLES must be >= 2");
  end

  state_e                              state_q, state_d;
  logic [SUB_W-1:0]                    substep_q;
  logic [NUM_WHEELS-1:0][1:0][ACC_W-1:0] acc;
  logic                                start, accept, wd_expire;

  assign start  = (state_q == ST_IDLE) && frame_in && !pause_in;
  assign accept = (state_q == ST_WAIT) && done_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      // A done in the expiry cycle still counts; abort only without one.
      ST_WAIT:    if (done_in)        state_d = ST_NEXT;
                  else if (wd_expire) state_d = ST_IDLE;
      ST_NEXT:    if (wheel_sel_out != LAST_WHEEL || substep_q != LAST_SUB) state_d = ST_ISSUE;
                  else                                                      state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      begin_out      <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      overrun_out    <= 1'b0;
      wheel_sel_out  <= '0;
      substep_q      <= '0;
      forces_out     <= '0;
    end else begin
      state_q        <= state_d;
      begin_out      <= (state_d == ST_ISSUE);
      busy_out       <= (state_d != ST_IDLE);
      frame_done_out <= (state_d == ST_PUBLISH);
      if (frame_in && state_q != ST_IDLE) overrun_out <= 1'b1;
      if (start) begin
        wheel_sel_out <= '0;
        substep_q     <= '0;
      end
      if (state_q == ST_NEXT) begin
        if (wheel_sel_out != LAST_WHEEL) begin
          wheel_sel_out <= wheel_sel_out + 1'b1;
        end else begin
          wheel_sel_out <= '0;
          if (substep_q != LAST_SUB) substep_q <= substep_q + 1'b1;
        end
      end
      // Last accumulate happened on the WAIT->NEXT edge, so acc is final here.
      if (state_d == ST_PUBLISH) forces_out <= acc;
    end
  end

  // Per-wheel accumulators; sign-extended adds never wrap at ACC_W.
  for (genvar w = 0; w < NUM_WHEELS; w++) begin : g_wheel
    logic [1:0][ACC_W-1:0] acc_q;
    logic                  hit;
    assign hit    = accept && (wheel_sel_out == SEL_W'(w));
    assign acc[w] = acc_q;
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        acc_q <= '0;
      end else if (start) begin
        acc_q <= '0;
      end else if (hit) begin
        for (int a = 0; a < 2; a++)
          acc_q[a] <= acc_q[a] + {{EXT_W{force_in[a][FORCE_SIZE-1]}}, force_in[a]};
      end
    end
  end

`ifdef UPDATE_WATCHDOG_EN
  // Count starts at the ISSUE cycle, so expiry lands TIMEOUT_CYCLES after begin.
  update_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk_in),
    .rst    (rst_in),
    .clear  (state_d == ST_ISSUE),
    .run    (state_q == ST_ISSUE || state_q == ST_WAIT),
    .expire (wd_expire)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                          error_out <= 1'b0;
    else if (state_q == ST_WAIT && !done_in && wd_expire) error_out <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign error_out = 1'b0;
`endif

endmodule

// File: doc/wheel_update_scheduler.md
# wheel_update_scheduler

Frame-level sequencer for the shared wheel physics updater. On each frame tick it runs SUBSTEPS physics substeps. Each substep updates every wheel in turn through one shared updater instance, using a begin/done handshake and a wheel-select output. It accumulates each wheel's axle force over the frame and publishes the per-frame totals to the chassis/drive logic.

## Interface
- NUM_WHEELS, 2, number of wheels sharing the updater (≥2)
- SUBSTEPS, 4, substeps per frame (power of two, ≥2)
- FORCE_SIZE, 8, signed width of updater axle force
- TIMEOUT_CYCLES, 4096, watchdog limit in cycles
- ACC_W (localparam) = FORCE_SIZE+$clog2(SUBSTEPS)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; one clock, reset asynchronous and active-high
- frame_in  in  1  one-cycle frame tick
- pause_in  in  1  high: frame ticks ignored while IDLE
- begin_out  out  1  one-cycle start pulse to updater
- wheel_sel_out  out  $clog2(NUM_WHEELS)  wheel currently routed to updater
- done_in  in  1  updater completion pulse
- force_in  in  signed FORCE_SIZE ×[1:0]  updater axle force (x,y), valid with done_in
- forces_out  out  signed ACC_W ×[1:0][NUM_WHEELS]  per-frame force sums
- frame_done_out  out  1  one-cycle pulse; forces_out just updated
- busy_out  out  1  high in any state but IDLE
- overrun_out  out  1  sticky: frame_in arrived while busy
- error_out  out  1  sticky: watchdog expired

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, PUBLISH.
- IDLE: frame_in=1 and pause_in=0 → ISSUE; wheel=0, substep=0, accumulators cleared.
- ISSUE: exactly one cycle, begin_out=1 → WAIT.
- WAIT: on done_in, acc[wheel] += sign-extended force_in (x and y separately) → NEXT. done_in is ignored in every state other than WAIT.
- NEXT: one cycle.
  - If wheel<NUM_WHEELS-1: wheel++ → ISSUE.
  - Else: wheel=0. If substep<SUBSTEPS-1: substep++ → ISSUE. Else → PUBLISH.
- PUBLISH: one cycle.
  - forces_out was loaded on the entry edge; frame_done_out=1 → IDLE.
- wheel_sel_out equals the internal wheel counter; it is stable from ISSUE through NEXT.
- ACC_W holds SUBSTEPS×(±full scale) exactly: no saturation, no wrap.
- frame_in while busy: frame dropped, overrun_out set. frame_in in IDLE with pause_in=1: ignored, no flag. pause_in mid-frame has no effect.
- frame_in in the PUBLISH cycle counts as busy (overrun).

## Timing
- Reset values: begin_out=0, wheel_sel_out=0, forces_out=all 0, frame_done_out=0, busy_out=0, overrun_out=0, error_out=0; state IDLE.
- Reset mid-frame: immediate return to IDLE. Counters and accumulators clear; forces_out clears. A later done_in is ignored.
- Per update: 1 (ISSUE) + d (WAIT, where done_in arrives d cycles after begin_out) + 1 (NEXT).
- Frame latency: frame_done_out rises NUM_WHEELS×SUBSTEPS×(d+2) cycles after the edge sampling frame_in. With defaults and d=3 this is 40 cycles.
- All outputs are registered.

## Configuration
- UPDATE_WATCHDOG_EN defined:
  - A cycle counter runs in WAIT and restarts at each ISSUE.
  - Reaching TIMEOUT_CYCLES without done_in sets error_out and aborts to IDLE.
  - On abort: no frame_done_out, forces_out unchanged.
- UPDATE_WATCHDOG_EN undefined: WAIT is unbounded; error_out is tied 0.

## Structure
- Package wheel_sched_pkg holds:
  - the state enum
  - the ACC_W helper function
  - a force-pair typedef
- One sub-module: update_watchdog (counter, clear, expire pulse). It is instantiated only under UPDATE_WATCHDOG_EN.

## Test plan
- Nominal frame. Defaults; responder returns done 3 cycles after begin with wheel0 force (+5,−2) and wheel1 force (−1,+1) every substep. Required: frame_done 40 cycles after the tick; forces_out wheel0=(20,−8), wheel1=(−4,4); wheel_sel sequence 0,1 repeated 4 times.
- Full-scale accumulation. Force (+127,−128) on every update. Required: forces_out=(508,−512) for both wheels; no wrap.
- Overrun. Second frame_in 10 cycles into a frame. Required: overrun_out=1; exactly one frame_done; no extra begin pulses.
- Pause. pause_in=1 with frame_in in IDLE. Required: no begin_out; busy_out stays 0; overrun_out stays 0.
- Watchdog (TIMEOUT_CYCLES=16, macro defined). Responder never asserts done. Required: error_out=1 16 cycles after begin; IDLE; no frame_done; forces_out retains the previous frame's values.
- Reset mid-frame. Assert rst_in during the third WAIT, then release and deliver a stray done_in. Required: all outputs at reset values; stray done ignored; the next frame completes normally.
